// File: rtl/sprite_pkg.sv
// Shared types, constants and the sprite-index helper for the sprite blitter.
package sprite_pkg;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE,
        DONE
    } blit_state_t;

    localparam rgb565_t TRANSPARENT_KEY = 16'hFFFF;
    localparam int      DEF_SCREEN_W    = 320;
    localparam int      DEF_SCREEN_H    = 240;
    localparam int      PIX_W           = 17;

    // Row-major sprite index; a mirrored column is used when flip is set.
    function automatic logic [PIX_W-1:0] pixel_index(
        input logic [5:0] row,
        input logic [5:0] col,
        input logic [5:0] width,
        input logic       flip
    );
        logic [5:0] c;
        c = flip ? (width - 6'd1 - col) : col;
        return PIX_W'(row) * PIX_W'(width) + PIX_W'(c);
    endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Column/row walker, sprite ROM index register and screen address/clip
// calculation for the sprite blitter.
module blit_addr_gen
    import sprite_pkg::*;
#(
    parameter int      SCREEN_W    = DEF_SCREEN_W,
    parameter int      SCREEN_H    = DEF_SCREEN_H,
    parameter rgb565_t TRANSPARENT = TRANSPARENT_KEY,
    parameter int      FB_AW       = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             capture,
    input  logic             advance,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    input  logic [5:0]       spr_width,
    input  logic [5:0]       spr_height,
    input  logic             flip_h,
    input  rgb565_t          spr_color,
    output logic [PIX_W-1:0] spr_pixel,
    output logic [FB_AW-1:0] fb_addr,
    output rgb565_t          fb_data,
    output logic             skip,
    output logic             empty,
    output logic             last
);

    logic [9:0]  px_q, py_q;
    logic [5:0]  w_q, h_q, col_q, row_q;
    logic [5:0]  w_d, col_d, row_d;
    logic        flip_q, flip_d;
    logic        col_wrap, row_wrap;
    logic [10:0] sx, sy;

    assign col_wrap = ({1'b0, col_q} + 7'd1) >= {1'b0, w_q};
    assign row_wrap = ({1'b0, row_q} + 7'd1) >= {1'b0, h_q};
    assign last     = col_wrap && row_wrap;
    assign empty    = (w_q == 6'd0) || (h_q == 6'd0);

    // 11-bit sums so an off-screen position can never wrap back on-screen.
    assign sx = {1'b0, px_q} + {5'd0, col_q};
    assign sy = {1'b0, py_q} + {5'd0, row_q};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        w_d    = w_q;
        flip_d = flip_q;
        if (load) begin
            col_d  = 6'd0;
            row_d  = 6'd0;
            w_d    = spr_width;
            flip_d = flip_h;
        end else if (advance) begin
            if (!col_wrap) begin
                col_d = col_q + 6'd1;
            end else begin
                col_d = 6'd0;
                if (!row_wrap) row_d = row_q + 6'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q      <= '0;
            py_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            flip_q    <= 1'b0;
            spr_pixel <= '0;
            fb_addr   <= '0;
            fb_data   <= '0;
            skip      <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            w_q       <= w_d;
            flip_q    <= flip_d;
            spr_pixel <= pixel_index(row_d, col_d, w_d, flip_d);
            if (load) begin
                px_q <= pos_x;
                py_q <= pos_y;
                h_q  <= spr_height;
            end
            if (capture) begin
                fb_data <= spr_color;
                fb_addr <= FB_AW'(sy) * FB_AW'(SCREEN_W) + FB_AW'(sx);
                skip    <= (spr_color == TRANSPARENT) ||
                           (sx >= 11'(SCREEN_W)) || (sy >= 11'(SCREEN_H));
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter top: IDLE/FETCH/WRITE/DONE control and frame-buffer handshake.
// Define SPRITE_BLIT_FLIP_EN to add the flip_h port for horizontal mirroring.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int          SCREEN_W    = DEF_SCREEN_W,
    parameter int          SCREEN_H    = DEF_SCREEN_H,
    parameter logic [15:0] TRANSPARENT = TRANSPARENT_KEY,
    parameter int          FB_AW       = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
`ifdef SPRITE_BLIT_FLIP_EN
    input  logic             flip_h,
`endif
    output logic [16:0]      spr_pixel,
    input  logic [15:0]      spr_color,
    input  logic [5:0]       spr_width,
    input  logic [5:0]       spr_height,
    output logic             fb_wr_valid,
    input  logic             fb_wr_ready,
    output logic [FB_AW-1:0] fb_wr_addr,
    output logic [15:0]      fb_wr_data,
    output logic             busy,
    output logic             done
);

    blit_state_t state_q, state_d;
    logic        load, capture, advance;
    logic        skip, empty, last;
    logic        flip_sel;

`ifdef SPRITE_BLIT_FLIP_EN
    assign flip_sel = flip_h;
`else
    assign flip_sel = 1'b0;
`endif

    blit_addr_gen #(
        .SCREEN_W    (SCREEN_W),
        .SCREEN_H    (SCREEN_H),
        .TRANSPARENT (TRANSPARENT),
        .FB_AW       (FB_AW)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .capture    (capture),
        .advance    (advance),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .spr_width  (spr_width),
        .spr_height (spr_height),
        .flip_h     (flip_sel),
        .spr_color  (spr_color),
        .spr_pixel  (spr_pixel),
        .fb_addr    (fb_wr_addr),
        .fb_data    (fb_wr_data),
        .skip       (skip),
        .empty      (empty),
        .last       (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A zero-sized sprite is detected on the latched size in FETCH and exits straight to DONE.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (empty) begin
                    state_d = DONE;
                end else begin
                    capture = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (skip || fb_wr_ready) begin
                    advance = 1'b1;
                    state_d = last ? DONE : FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decoded from the state register so an asynchronous reset drops them at once.
    assign fb_wr_valid = (state_q == WRITE) && !skip;
    assign busy        = (state_q == FETCH) || (state_q == WRITE);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed corner cases plus random
// blits scored against a per-pixel reference model of the blit rules.
`timescale 1ns/1ps
module tb_sprite_blitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic [16:0] spr_pixel;
    logic [15:0] spr_color;
    logic [5:0]  spr_width = '0;
    logic [5:0]  spr_height = '0;
    logic        fb_wr_valid;
    logic        fb_wr_ready = 1'b0;
    logic [16:0] fb_wr_addr;
    logic [15:0] fb_wr_data;
    logic        busy;
    logic        done;
`ifdef SPRITE_BLIT_FLIP_EN
    logic        flip_h = 1'b0;
`endif

    logic [15:0] rom [4096];
    logic [32:0] obs_q [$];
    logic [32:0] exp_q [$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int stall_cnt = 0;
    int start_cyc, base_obs, base_done, base_stall, exp_w, exp_h, last_lat;
    bit   ready_rand = 1'b0;
    logic ready_force = 1'b1;

    sprite_blitter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
`ifdef SPRITE_BLIT_FLIP_EN
        .flip_h      (flip_h),
`endif
        .spr_pixel   (spr_pixel),
        .spr_color   (spr_color),
        .spr_width   (spr_width),
        .spr_height  (spr_height),
        .fb_wr_valid (fb_wr_valid),
        .fb_wr_ready (fb_wr_ready),
        .fb_wr_addr  (fb_wr_addr),
        .fb_wr_data  (fb_wr_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    assign spr_color = (spr_pixel < 17'd4096) ? rom[spr_pixel[11:0]] : 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        fb_wr_ready = ready_rand ? ($urandom_range(0, 1) == 1) : ready_force;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (fb_wr_valid && fb_wr_ready) obs_q.push_back({fb_wr_addr, fb_wr_data});
            if (fb_wr_valid && !fb_wr_ready) stall_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: every sprite pixel in row-major order, kept if opaque and on-screen.
    task automatic build_model(input int px, input int py, input int w, input int h, input bit flip);
        exp_q.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int idx, x, y;
                idx = r * w + (flip ? (w - 1 - c) : c);
                x = px + c;
                y = py + r;
                if (rom[idx] != 16'hFFFF && x < 320 && y < 240)
                    exp_q.push_back({17'(y * 320 + x), rom[idx]});
            end
        end
    endtask

    task automatic start_blit(input int px, input int py, input int w, input int h, input bit flip);
        build_model(px, py, w, h, flip);
        exp_w      = w;
        exp_h      = h;
        base_obs   = obs_q.size();
        base_done  = done_cnt;
        base_stall = stall_cnt;
        @(posedge clk); #1;
        pos_x      = 10'(px);
        pos_y      = 10'(py);
        spr_width  = 6'(w);
        spr_height = 6'(h);
`ifdef SPRITE_BLIT_FLIP_EN
        flip_h     = flip;
`endif
        start      = 1'b1;
        start_cyc  = cyc;
        @(posedge clk); #1;
        start      = 1'b0;
        spr_width  = 6'($urandom);
        spr_height = 6'($urandom);
        pos_x      = 10'($urandom);
        check("busy_after_start", busy, 1);
    endtask

    task automatic finish_blit(input string tag);
        int n_obs, n_exp, n_cmp;
        for (int i = 0; i < 20000 && done_cnt == base_done; i++) begin
            @(negedge clk); #1;
        end
        check({tag, "/done_seen"}, done_cnt - base_done, 1);
        last_lat = done_cyc - start_cyc;
        if (exp_w == 0 || exp_h == 0)
            check({tag, "/latency"}, last_lat, 2);
        else
            check({tag, "/latency"}, last_lat, 2 * exp_w * exp_h + 1 + (stall_cnt - base_stall));
        n_obs = obs_q.size() - base_obs;
        n_exp = exp_q.size();
        check({tag, "/write_count"}, n_obs, n_exp);
        n_cmp = (n_obs < n_exp) ? n_obs : n_exp;
        for (int i = 0; i < n_cmp; i++)
            check({tag, "/write"}, obs_q[base_obs + i], exp_q[i]);
        @(negedge clk); #1;
        @(negedge clk); #1;
        check({tag, "/single_done"}, done_cnt - base_done, 1);
        check({tag, "/idle_busy"}, busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;

        // Reset state
        #12;
        check("reset/valid", fb_wr_valid, 0);
        check("reset/busy", busy, 0);
        check("reset/done", done, 0);
        check("reset/pixel", spr_pixel, 0);
        check("reset/addr", fb_wr_addr, 0);
        check("reset/data", fb_wr_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3x2 solid sprite at (10,20)
        for (int i = 0; i < 6; i++) rom[i] = 16'h1234;
        start_blit(10, 20, 3, 2, 1'b0);
        finish_blit("solid");
        check("solid/latency13", last_lat, 13);
        if (obs_q.size() >= base_obs + 6) begin
            check("solid/first_addr", obs_q[base_obs][32:16], 6410);
            check("solid/last_addr", obs_q[base_obs + 5][32:16], 6732);
        end

        // Transparent key
        rom[0] = 16'hFFFF; rom[1] = 16'h2082; rom[2] = 16'hFFFF; rom[3] = 16'h05A4;
        start_blit(0, 0, 2, 2, 1'b0);
        finish_blit("transp");
        if (obs_q.size() >= base_obs + 2) begin
            check("transp/w0", obs_q[base_obs], {17'd1, 16'h2082});
            check("transp/w1", obs_q[base_obs + 1], {17'd321, 16'h05A4});
        end

        // Bottom-right corner clip
        for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h07E0;
        start_blit(319, 239, 29, 33, 1'b0);
        finish_blit("corner");
        if (obs_q.size() > base_obs)
            check("corner/w0", obs_q[base_obs], {17'd76799, 16'h07E0});

        // Stall on first write for 5 cycles
        for (int i = 0; i < 6; i++) rom[i] = 16'h0100 + 16'(i);
        ready_force = 1'b0;
        start_blit(10, 20, 3, 2, 1'b0);
        for (int i = 0; i < 10 && !fb_wr_valid; i++) begin
            @(negedge clk); #1;
        end
        check("stall/valid", fb_wr_valid, 1);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk); #1;
            check("stall/valid_hold", fb_wr_valid, 1);
            check("stall/addr_hold", fb_wr_addr, 6410);
            check("stall/data_hold", fb_wr_data, 16'h0100);
        end
        ready_force = 1'b1;
        finish_blit("stall");
        check("stall/cycles", stall_cnt - base_stall, 5);
        check("stall/latency18", last_lat, 18);

        // Zero-sized sprites
        start_blit(5, 5, 0, 4, 1'b0);
        finish_blit("w0");
        start_blit(5, 5, 4, 0, 1'b0);
        finish_blit("h0");

        // Start while busy is ignored
        for (int i = 0; i < 4096; i++) rom[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        start_blit(30, 40, 3, 3, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        pos_x = 10'd0; pos_y = 10'd0; spr_width = 6'd2; spr_height = 6'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_blit("busy_start");

        // Reset during third write
        for (int i = 0; i < 6; i++) rom[i] = 16'h0300 + 16'(i);
        start_blit(10, 20, 3, 2, 1'b0);
        while (cyc < start_cyc + 6) begin
            @(negedge clk); #1;
        end
        check("rst_mid/valid_before", fb_wr_valid, 1);
        check("rst_mid/addr_before", fb_wr_addr, 6412);
        rst_n = 1'b0;
        #1;
        check("rst_mid/valid_async", fb_wr_valid, 0);
        check("rst_mid/busy_async", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mid/no_done", done_cnt - base_done, 0);
        check("rst_mid/busy_idle", busy, 0);
        start_blit(300, 230, 5, 3, 1'b0);
        finish_blit("after_rst");

`ifdef SPRITE_BLIT_FLIP_EN
        // Mirrored 3x1 sprite reads indices 2,1,0
        rom[0] = 16'h000A; rom[1] = 16'h000B; rom[2] = 16'h000C;
        start_blit(50, 60, 3, 1, 1'b1);
        finish_blit("flip");
        if (obs_q.size() >= base_obs + 3) begin
            check("flip/d0", obs_q[base_obs][15:0], 16'h000C);
            check("flip/d2", obs_q[base_obs + 2][15:0], 16'h000A);
        end
`endif

        // Random blits with random backpressure
        ready_rand = 1'b1;
        for (int n = 0; n < 20; n++) begin
            bit fl;
            for (int i = 0; i < 128; i++) rom[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
`ifdef SPRITE_BLIT_FLIP_EN
            fl = 1'($urandom);
`else
            fl = 1'b0;
`endif
            start_blit($urandom_range(0, 330), $urandom_range(0, 250),
                       $urandom_range(0, 9), $urandom_range(0, 9), fl);
            finish_blit("random");
        end
        ready_rand = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
